// File: rtl/wb_axi4lite_bridge_pkg.sv
// Shared types and constants for the Wishbone B4 pipelined to AXI4-Lite bridge.
package wb_axi4lite_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_WRESP = 3'd2,
        ST_READ  = 3'd3,
        ST_RRESP = 3'd4,
        ST_DONE  = 3'd5,
        ST_DRAIN = 3'd6
    } state_t;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_EXOKAY  = 2'b01;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [1:0] RESP_DECERR  = 2'b11;
    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    // EXOKAY is deliberately folded into the OK class.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

    // Width needed to hold TIMEOUT-1 (the counter is loaded with one less than the budget).
    function automatic int cnt_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/wb_axi4lite_bridge_timeout_cnt.sv
// Loadable down-counter that saturates at zero; expired flags an enabled zero count.
module bridge_timeout_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: load wins, otherwise decrement while enabled and non-zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != {WIDTH{1'b0}})) begin
            cnt_d = cnt_q - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == {WIDTH{1'b0}});

endmodule

// File: rtl/wb_axi4lite_bridge.sv
// Wishbone B4 pipelined slave to AXI4-Lite master, one transaction in flight,
// with a response timeout so the Wishbone side can never hang.
module wb_axi4lite_bridge
    import wb_axi4lite_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [3:0]            wb_sel_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  wb_stall_o,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [2:0]            awprot,
    output logic                  wvalid,
    input  logic                  wready,
    output logic [31:0]           wdata,
    output logic [3:0]            wstrb,
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [1:0]            bresp,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [2:0]            arprot,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [31:0]           rdata,
    input  logic [1:0]            rresp
);

    localparam int                    CNT_W     = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0]      CNT_LOAD  = (TIMEOUT == 0) ? {CNT_W{1'b0}} : CNT_W'(TIMEOUT - 1);
    localparam logic                  TMO_ON    = (TIMEOUT != 0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;
    logic                  cyc_lost_q, cyc_lost_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  bready_q, bready_d;
    logic                  rready_q, rready_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [31:0]           dat_q, dat_d;
    logic                  ack_q, ack_d;
    logic                  werr_q, werr_d;
    logic                  stall_q, stall_d;
    logic                  cnt_load;
    logic                  cnt_en;
    logic                  tmo_expired;

    bridge_timeout_cnt #(
        .WIDTH (CNT_W)
    ) u_tmo (
        .clk      (aclk),
        .rst      (areset),
        .load     (cnt_load),
        .en       (cnt_en & TMO_ON),
        .load_val (CNT_LOAD),
        .expired  (tmo_expired)
    );

    // Next-state, AXI channel and Wishbone response logic.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        err_d      = err_q;
        cyc_lost_d = cyc_lost_q | ~wb_cyc_i;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        arvalid_d  = arvalid_q;
        awaddr_d   = awaddr_q;
        araddr_d   = araddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        dat_d      = dat_q;
        ack_d      = 1'b0;
        werr_d     = 1'b0;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cyc_lost_d = 1'b0;
                err_d      = 1'b0;
                if (wb_cyc_i && wb_stb_i) begin
                    cnt_load = 1'b1;
                    we_d     = wb_we_i;
                    if (wb_we_i) begin
                        awaddr_d  = wb_adr_i & ADDR_MASK;
                        wdata_d   = wb_dat_i;
                        wstrb_d   = wb_sel_i;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WRITE;
                    end else begin
                        araddr_d  = wb_adr_i & ADDR_MASK;
                        arvalid_d = 1'b1;
                        state_d   = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                cnt_en    = 1'b1;
                awvalid_d = awvalid_q & ~awready;
                wvalid_d  = wvalid_q & ~wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d = ST_WRESP;
                end else if (tmo_expired) begin
                    werr_d  = ~cyc_lost_d;
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRESP: begin
                cnt_en = 1'b1;
                if (bvalid) begin
                    err_d   = resp_is_err(bresp);
                    state_d = ST_DONE;
                end else if (tmo_expired) begin
                    werr_d  = ~cyc_lost_d;
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_WRESP;
                end
            end
            ST_READ: begin
                cnt_en = 1'b1;
                if (arready) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_RRESP;
                end else if (tmo_expired) begin
                    werr_d  = ~cyc_lost_d;
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_RRESP: begin
                cnt_en = 1'b1;
                if (rvalid) begin
                    dat_d   = rdata;
                    err_d   = resp_is_err(rresp);
                    state_d = ST_DONE;
                end else if (tmo_expired) begin
                    werr_d  = ~cyc_lost_d;
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RRESP;
                end
            end
            ST_DONE: begin
                ack_d   = ~err_q & ~cyc_lost_d;
                werr_d  = err_q & ~cyc_lost_d;
                state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                // Pending valids stay up until accepted; the late response is dropped.
                awvalid_d = awvalid_q & ~awready;
                wvalid_d  = wvalid_q & ~wready;
                arvalid_d = arvalid_q & ~arready;
                if ((we_q && bvalid) || (!we_q && rvalid)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        bready_d = (state_d == ST_WRESP) || ((state_d == ST_DRAIN) && we_q);
        rready_d = (state_d == ST_RRESP) || ((state_d == ST_DRAIN) && !we_q);
        stall_d  = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            cyc_lost_q <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            bready_q   <= 1'b0;
            rready_q   <= 1'b0;
            awaddr_q   <= {ADDR_WIDTH{1'b0}};
            araddr_q   <= {ADDR_WIDTH{1'b0}};
            wdata_q    <= 32'h0000_0000;
            wstrb_q    <= 4'h0;
            dat_q      <= 32'h0000_0000;
            ack_q      <= 1'b0;
            werr_q     <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            err_q      <= err_d;
            cyc_lost_q <= cyc_lost_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            arvalid_q  <= arvalid_d;
            bready_q   <= bready_d;
            rready_q   <= rready_d;
            awaddr_q   <= awaddr_d;
            araddr_q   <= araddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            dat_q      <= dat_d;
            ack_q      <= ack_d;
            werr_q     <= werr_d;
            stall_q    <= stall_d;
        end
    end

    assign wb_dat_o   = dat_q;
    assign wb_ack_o   = ack_q;
    assign wb_err_o   = werr_q;
    assign wb_stall_o = stall_q;
    assign awvalid    = awvalid_q;
    assign awaddr     = awaddr_q;
    assign awprot     = PROT_DEFAULT;
    assign wvalid     = wvalid_q;
    assign wdata      = wdata_q;
    assign wstrb      = wstrb_q;
    assign bready     = bready_q;
    assign arvalid    = arvalid_q;
    assign araddr     = araddr_q;
    assign arprot     = PROT_DEFAULT;
    assign rready     = rready_q;

endmodule

// File: tb/tb_wb_axi4lite_bridge.sv
// Directed self-checking bench for wb_axi4lite_bridge; the AXI slave is driven step by step.
module tb_wb_axi4lite_bridge;

    logic        aclk = 1'b0;
    logic        areset;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [31:0] wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o, wb_stall_o;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    int n_cmp = 0;
    int n_bad = 0;

    wb_axi4lite_bridge #(.ADDR_WIDTH(32), .TIMEOUT(8)) dut (
        .aclk(aclk), .areset(areset),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_stall_o(wb_stall_o),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Write with a zero-wait slave; response code chooses ack or err.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] resp);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = a; wb_dat_i = d; wb_sel_i = s;
        tick();
        wb_stb_i = 1'b0;
        chk("wr_awvalid", awvalid, 1);
        chk("wr_wvalid", wvalid, 1);
        chk("wr_awaddr", awaddr, a & 32'hFFFF_FFFC);
        chk("wr_wdata", wdata, d);
        chk("wr_wstrb", wstrb, s);
        chk("wr_stall", wb_stall_o, 1);
        awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        chk("wr_valids_low", {awvalid, wvalid}, 0);
        chk("wr_bready", bready, 1);
        bvalid = 1'b1; bresp = resp;
        tick();
        bvalid = 1'b0; bresp = 2'b00;
        chk("wr_ack_early", {wb_ack_o, wb_err_o}, 0);
        tick();
        chk("wr_ack", wb_ack_o, !resp[1]);
        chk("wr_err", wb_err_o, resp[1]);
        chk("wr_stall_end", wb_stall_o, 0);
        wb_cyc_i = 1'b0;
        tick();
        chk("wr_pulse_once", {wb_ack_o, wb_err_o}, 0);
    endtask

    // Read with immediate arready and a configurable number of response wait cycles.
    task automatic do_read(input logic [31:0] a, input int waits, input logic [31:0] d,
                           input logic [1:0] resp);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = a;
        tick();
        wb_stb_i = 1'b0;
        chk("rd_arvalid", arvalid, 1);
        chk("rd_araddr", araddr, a & 32'hFFFF_FFFC);
        chk("rd_stall", wb_stall_o, 1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("rd_arvalid_low", arvalid, 0);
        chk("rd_rready", rready, 1);
        for (int i = 0; i < waits; i++) begin
            tick();
            chk("rd_wait_stall", wb_stall_o, 1);
            chk("rd_wait_noack", {wb_ack_o, wb_err_o}, 0);
        end
        rvalid = 1'b1; rdata = d; rresp = resp;
        tick();
        rvalid = 1'b0; rresp = 2'b00;
        chk("rd_rready_low", rready, 0);
        chk("rd_done_stall", wb_stall_o, 1);
        tick();
        chk("rd_ack", wb_ack_o, !resp[1]);
        chk("rd_err", wb_err_o, resp[1]);
        chk("rd_data", wb_dat_o, d);
        chk("rd_stall_end", wb_stall_o, 0);
        wb_cyc_i = 1'b0;
        tick();
        chk("rd_pulse_once", {wb_ack_o, wb_err_o}, 0);
        chk("rd_data_hold", wb_dat_o, d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        areset = 1'b1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = 32'h0; wb_sel_i = 4'h0; wb_dat_i = 32'h0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        tick();
        tick();
        chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
        chk("rst_wb", {wb_ack_o, wb_err_o, wb_stall_o}, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_prot", {awprot, arprot}, 0);
        areset = 1'b0;
        tick();

        // 1: zero-wait write, ack four cycles after the strobe
        do_write(32'h0000_000C, 32'hDEAD_BEEF, 4'hF, 2'b00);

        // 2: read with five response wait cycles
        do_read(32'h0000_0010, 5, 32'h1234_5678, 2'b00);

        // 3: awready three cycles ahead of wready
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 32'h0000_0016; wb_dat_i = 32'hA5A5_A5A5; wb_sel_i = 4'h3;
        tick();
        wb_stb_i = 1'b0;
        chk("t3_awaddr", awaddr, 32'h0000_0014);
        chk("t3_wstrb", wstrb, 4'h3);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        chk("t3_aw_dropped", awvalid, 0);
        chk("t3_w_held1", wvalid, 1);
        tick();
        chk("t3_w_held2", wvalid, 1);
        tick();
        chk("t3_w_held3", wvalid, 1);
        chk("t3_aw_stays_low", awvalid, 0);
        wready = 1'b1;
        tick();
        wready = 1'b0;
        chk("t3_w_dropped", wvalid, 0);
        chk("t3_bready", bready, 1);
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        chk("t3_no_ack_yet", wb_ack_o, 0);
        tick();
        chk("t3_ack", wb_ack_o, 1);
        wb_cyc_i = 1'b0;
        tick();
        chk("t3_ack_once", wb_ack_o, 0);
        chk("t3_dat_hold", wb_dat_o, 32'h1234_5678);

        // 4: error responses
        do_write(32'h0000_0020, 32'h0BAD_F00D, 4'hF, 2'b10);
        do_read(32'h0000_0024, 0, 32'hE0E0_E0E0, 2'b11);
        do_write(32'h0000_0028, 32'h0000_0001, 4'h1, 2'b01);

        // 5: timeout on a read that never responds, late rvalid discarded
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0000_0030;
        tick();
        wb_stb_i = 1'b0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int c = 2; c <= 8; c++) begin
            chk("t5_no_err_early", wb_err_o, 0);
            if (c < 8) tick();
        end
        tick();
        chk("t5_err", wb_err_o, 1);
        chk("t5_ack_low", wb_ack_o, 0);
        chk("t5_drain_stall", wb_stall_o, 1);
        chk("t5_drain_rready", rready, 1);
        for (int c = 10; c <= 20; c++) begin
            tick();
            chk("t5_err_once", wb_err_o, 0);
            chk("t5_stall_held", wb_stall_o, 1);
        end
        rvalid = 1'b1; rdata = 32'hBAD0_BAD0;
        tick();
        rvalid = 1'b0;
        chk("t5_idle", wb_stall_o, 0);
        chk("t5_rready_low", rready, 0);
        chk("t5_no_pulse", {wb_ack_o, wb_err_o}, 0);
        chk("t5_discarded", wb_dat_o, 32'hE0E0_E0E0);
        wb_cyc_i = 1'b0;
        tick();
        do_write(32'h0000_0034, 32'hCAFE_0001, 4'hF, 2'b00);

        // 6a: reset in the middle of a write
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 32'h0000_0040; wb_dat_i = 32'h1111_2222; wb_sel_i = 4'hC;
        tick();
        chk("t6_in_write", awvalid, 1);
        areset = 1'b1;
        #1;
        chk("t6_rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
        chk("t6_rst_wb", {wb_ack_o, wb_err_o, wb_stall_o}, 0);
        chk("t6_rst_regs", {awaddr, wdata}, 0);
        chk("t6_rst_wstrb", wstrb, 0);
        chk("t6_rst_dat", wb_dat_o, 0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        #2;
        areset = 1'b0;
        tick();

        // 6b: cyc dropped mid-read; AXI completes, no Wishbone pulse
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0000_0044;
        tick();
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        chk("t6_arvalid", arvalid, 1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("t6_rready", rready, 1);
        rvalid = 1'b1; rdata = 32'h55AA_55AA;
        tick();
        rvalid = 1'b0;
        chk("t6_rready_low", rready, 0);
        tick();
        chk("t6_no_pulse", {wb_ack_o, wb_err_o}, 0);
        chk("t6_idle", wb_stall_o, 0);
        tick();
        chk("t6_no_pulse_late", {wb_ack_o, wb_err_o}, 0);
        do_write(32'h0000_0048, 32'h7777_8888, 4'hF, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
